// File: rtl/instr_mem_loader_if.sv
// Fetch/decode and program-load signal bundle for instr_mem_loader.
// INSTR_HALT_EN adds the instr_halt signal.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 9
);
  logic [ADDR_W-1:0]  pc;
  logic               fetch_en;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_last;
  logic               load_ready;
  logic               load_done;
  logic               load_err;
  logic [ADDR_W:0]    load_count;
`ifdef INSTR_HALT_EN
  logic               instr_halt;
`endif

  modport master (
    output pc, fetch_en, load_valid, load_data, load_last,
    input  instr, instr_valid, load_ready, load_done, load_err, load_count
`ifdef INSTR_HALT_EN
    , input instr_halt
`endif
  );

  modport slave (
    input  pc, fetch_en, load_valid, load_data, load_last,
    output instr, instr_valid, load_ready, load_done, load_err, load_count
`ifdef INSTR_HALT_EN
    , output instr_halt
`endif
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with sequential program-load port and 1-cycle registered fetch.
// Optional INSTR_HALT_EN: flags all-ones words and locks fetch until the next load.
module instr_mem_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 9
) (
  input logic                i_clk,
  input logic                i_rst_n,
  instr_mem_loader_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

  state_t             r_state, w_state_nxt;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic               r_load_ready;
  logic               r_load_done;
  logic               r_load_err;
  logic [CNT_W-1:0]   r_load_count;

  logic               w_accept;
  logic               w_we;
  logic               w_fetch;
  logic               w_restart;
  logic               w_blocked;
  logic [ADDR_W-1:0]  w_waddr;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic [INSTR_W-1:0] w_rdata;

  assign w_accept = bus.load_valid & r_load_ready;
  assign w_rdata  = r_mem[bus.pc];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, write control and load status
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_fetch     = 1'b0;
    w_restart   = 1'b0;
    w_count_nxt = r_load_count;
    w_done_nxt  = r_load_done;
    w_err_nxt   = r_load_err;
    case (r_state)
      S_IDLE, S_READY: begin
        if (w_accept) begin
          w_restart   = 1'b1;
          w_we        = 1'b1;
          w_count_nxt = CNT_W'(1);
          w_err_nxt   = 1'b0;
          w_done_nxt  = bus.load_last;
          w_state_nxt = bus.load_last ? S_READY : S_LOAD;
        end else if ((r_state == S_READY) && bus.fetch_en && !w_blocked) begin
          w_fetch = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_we        = 1'b1;
          w_waddr     = r_load_count[ADDR_W-1:0];
          w_count_nxt = r_load_count + CNT_W'(1);
          if (bus.load_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_READY;
          end else if (r_load_count == CNT_W'(DEPTH - 1)) begin
            // Last address filled without Last: stop rather than wrap
            w_err_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_READY;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_load_ready  <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_load_count  <= '0;
    end else begin
      r_load_ready  <= 1'b1;
      r_instr_valid <= w_fetch;
      if (w_fetch) r_instr <= w_rdata;
      r_load_done   <= w_done_nxt;
      r_load_err    <= w_err_nxt;
      r_load_count  <= w_count_nxt;
    end
  end

  // Storage is deliberately not reset so a reset keeps the loaded program
  always_ff @(posedge i_clk) begin
    if (w_we) r_mem[w_waddr] <= bus.load_data;
  end

`ifdef INSTR_HALT_EN
  logic r_lock;
  logic r_halt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock <= 1'b0;
      r_halt <= 1'b0;
    end else begin
      r_halt <= w_fetch & (&w_rdata);
      if (w_restart)                r_lock <= 1'b0;
      else if (w_fetch && &w_rdata) r_lock <= 1'b1;
    end
  end

  assign w_blocked      = r_lock;
  assign bus.instr_halt = r_halt;
`else
  assign w_blocked = 1'b0;
`endif

  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.load_ready  = r_load_ready;
  assign bus.load_done   = r_load_done;
  assign bus.load_err    = r_load_err;
  assign bus.load_count  = r_load_count;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader; honours INSTR_HALT_EN when defined.
module tb_instr_mem_loader;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned DEPTH   = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int                 cyc;
    logic [INSTR_W-1:0] word;
    logic               halt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory image plus load/fetch bookkeeping
  logic [INSTR_W-1:0] mem_m [DEPTH];
  bit                 written [DEPTH];
  bit                 m_loading, m_can_fetch, m_locked, m_done, m_err, m_rdy;
  int                 m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_loading   = 1'b0;
    m_can_fetch = 1'b0;
    m_locked    = 1'b0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_rdy       = 1'b0;
    m_count     = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"},       32'(bus.instr),       0);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 0);
    chk({tag, "_load_ready"},  32'(bus.load_ready),  0);
    chk({tag, "_load_done"},   32'(bus.load_done),   0);
    chk({tag, "_load_err"},    32'(bus.load_err),    0);
    chk({tag, "_load_count"},  32'(bus.load_count),  0);
`ifdef INSTR_HALT_EN
    chk({tag, "_instr_halt"},  32'(bus.instr_halt),  0);
`endif
  endtask

  // Drive one cycle (called at posedge+1), predict its edge, check status after it
  task automatic cycle(input bit lv, input logic [INSTR_W-1:0] ld, input bit ll,
                       input bit fe, input logic [ADDR_W-1:0] pc);
    exp_t e;
    bus.load_valid = lv;
    bus.load_data  = ld;
    bus.load_last  = ll;
    bus.fetch_en   = fe;
    bus.pc         = pc;
    if (lv && m_rdy) begin
      if (!m_loading) begin
        m_count  = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_locked = 1'b0;
      end
      mem_m[m_count]   = ld;
      written[m_count] = 1'b1;
      m_count++;
      if (ll || m_count == DEPTH) begin
        m_done      = 1'b1;
        m_err       = !ll;
        m_loading   = 1'b0;
        m_can_fetch = 1'b1;
      end else begin
        m_loading   = 1'b1;
        m_can_fetch = 1'b0;
      end
    end else if (fe && m_can_fetch && !m_locked) begin
      e.cyc  = cyc + 1;
      e.word = mem_m[pc];
`ifdef INSTR_HALT_EN
      e.halt = (mem_m[pc] == 9'h1FF);
      if (e.halt) m_locked = 1'b1;
`else
      e.halt = 1'b0;
`endif
      sb.push_back(e);
    end
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("load_ready", 32'(bus.load_ready), 1);
    chk("load_count", 32'(bus.load_count), 32'(m_count));
    chk("load_done",  32'(bus.load_done),  32'(m_done));
    chk("load_err",   32'(bus.load_err),   32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [ADDR_W-1:0] safe_pc();
    logic [ADDR_W-1:0] p;
    p = ADDR_W'($urandom);
    if (!written[p]) p = '0;
    return p;
  endfunction

  // Asserted between edges so the clear is observed without a clock
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a fetched word
  logic [INSTR_W-1:0] last_instr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) last_instr = '0;
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missed_fetch: no instr_valid for word 0x%0h due cycle %0d", e.word, e.cyc);
    end
    if (bus.instr_valid === 1'b1) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: instr_valid=1 instr=0x%0h at cycle %0d, expected 0", bus.instr, cyc);
      end else begin
        e = sb.pop_front();
        chk("fetch_word", 32'(bus.instr), 32'(e.word));
`ifdef INSTR_HALT_EN
        chk("fetch_halt", 32'(bus.instr_halt), 32'(e.halt));
`endif
      end
      last_instr = bus.instr;
    end else begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_fetch: instr_valid=0, expected word 0x%0h at cycle %0d", e.word, cyc);
      end
      chk("instr_hold", 32'(bus.instr), 32'(last_instr));
`ifdef INSTR_HALT_EN
      chk("halt_idle", 32'(bus.instr_halt), 0);
`endif
    end
  end

  initial begin
    logic [INSTR_W-1:0] prog [4];
    prog[0] = 9'h001; prog[1] = 9'h0A5; prog[2] = 9'h1FE; prog[3] = 9'h123;
    bus.pc = '0; bus.fetch_en = 1'b0; bus.load_valid = 1'b0;
    bus.load_data = '0; bus.load_last = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      written[i] = 1'b0;
      mem_m[i]   = '0;
    end
    model_reset();
    #1;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fetches before any load are ignored
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h05);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h00);

    // Directed 4-word program, then read back
    for (int i = 0; i < 4; i++) cycle(1'b1, prog[i], i == 3, 1'b0, '0);
    for (int p = 0; p < 4; p++) cycle(1'b0, '0, 1'b0, 1'b1, ADDR_W'(p));
    idle(1);

    // Alternate-cycle load with fetch requests during LOAD
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, INSTR_W'($urandom), i == 2, 1'b1, '0);
      cycle(1'b0, '0, 1'b0, 1'b1, '0);
    end
    idle(1);

    // Full-depth load without Last overflows into READY
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, 1'b0, 1'b1, safe_pc());
      cycle(1'b1, INSTR_W'($urandom), 1'b0, 1'b0, '0);
    end
    cycle(1'b0, '0, 1'b0, 1'b1, 8'hFF);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h10);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h11);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h12);
    idle(2);

    // Restart from READY drops the simultaneous fetch; reset after 2 words
    cycle(1'b1, INSTR_W'($urandom), 1'b0, 1'b1, 8'h03);
    cycle(1'b1, INSTR_W'($urandom), 1'b0, 1'b0, '0);
    async_reset();
    idle(1);
    cycle(1'b1, INSTR_W'($urandom), 1'b1, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h01);
    idle(1);

`ifdef INSTR_HALT_EN
    cycle(1'b1, 9'h010, 1'b0, 1'b0, '0);
    cycle(1'b1, 9'h1FF, 1'b0, 1'b0, '0);
    cycle(1'b1, 9'h020, 1'b1, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h01);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h02);
    cycle(1'b0, '0, 1'b0, 1'b1, 8'h00);
    idle(1);
`endif

    // Random mixed traffic: short reloads interleaved with fetch bursts
    for (int i = 0; i < 400; i++) begin
      if (m_loading)
        cycle($urandom_range(0, 9) < 7, INSTR_W'($urandom), $urandom_range(0, 7) == 0,
              1'(($urandom)), safe_pc());
      else if ($urandom_range(0, 19) == 0)
        cycle(1'b1, ($urandom_range(0, 3) == 0) ? 9'h1FF : INSTR_W'($urandom),
              $urandom_range(0, 3) == 0, 1'b1, safe_pc());
      else
        cycle(1'b0, '0, 1'b0, $urandom_range(0, 9) < 8, safe_pc());
    end
    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
